// File: rtl/ahb_params_pkg.sv
// Shared AHB definitions for the SRAM slave.
//   htrans_e     : transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_e      : response encoding (OKAY/ERROR/RETRY/SPLIT)
//   HSIZE_*      : transfer size codes
//   sram_state_e : data-phase FSM states of the slave
//   byte_strobe  : little-endian byte lane enables for an access
package ahb_params_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sram_state_e;

  // Lane enables for a legal access; illegal sizes enable nothing.
  function automatic logic [3:0] byte_strobe(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised RAM bank: MEM_DEPTH x DATA_WIDTH flops.
//   clk_i      : clock
//   we_i       : per-byte write enables (bit n -> bits [8n+7:8n])
//   addr_i     : word index, shared by the write and read ports
//   wdata_i    : write data
//   rdata_o    : asynchronous read of the addressed word
// Contents are intentionally not reset.
module ahb_sram_bank #(
  parameter int MEM_DEPTH  = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk_i,
  input  logic [3:0]              we_i,
  input  logic [IDX_W-1:0]        addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Byte-lane write; lanes without an enable keep their old contents.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting an on-chip word RAM.
//   HCLK/HRESETn      : clock, synchronous active-low reset
//   HSEL..HREADY      : address/control/data inputs from the bus
//   HRDATA            : read data, valid in the completion cycle, held otherwise
//   HREADYOUT/HRESP   : this slave's ready and OKAY/ERROR response
//   HSPLIT            : constant zero (no split support)
// Transfers are accepted in ready cycles; WAIT_STATES low cycles are inserted
// per OKAY transfer, and illegal accesses get the two-cycle ERROR response.
module ahb_sram_slave
  import ahb_params_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int WAIT_STATES   = 0,
  parameter int NO_OF_MASTERS = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [ADDR_WIDTH-1:0]    HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [3:0]               HPROT,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  input  logic                     HREADY,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [NO_OF_MASTERS-1:0] HSPLIT
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] WINDOW = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES - 1);

  sram_state_e           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  dp_valid_q, dp_valid_d;
  logic [IDX_W+1:0]      addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  logic                  hreadyout_s;
  logic                  accept_s;
  logic                  err_s;
  logic                  complete_s;
  logic [3:0]            we_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  hresp_e                hresp_s;

  // Burst type, protection and the BUSY/IDLE distinction carry no meaning here.
  logic unused_s;
  assign unused_s = ^{HBURST, HPROT, HTRANS[0]};

  // Address-phase decode: acceptance and the error classification.
  always_comb begin
    accept_s = HSEL & HREADY & HTRANS[1] & hreadyout_s;
    err_s    = 1'b0;
    if ({1'b0, HADDR} >= WINDOW) begin
      err_s = 1'b1;
    end else if (HSIZE > HSIZE_WORD) begin
      err_s = 1'b1;
    end else if ((HSIZE == HSIZE_HALF) && HADDR[0]) begin
      err_s = 1'b1;
    end else if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Output decode from state, next-state and data-phase latches.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_valid_d  = dp_valid_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    err_d       = err_q;
    hreadyout_s = 1'b1;
    hresp_s     = HRESP_OKAY;

    case (state_q)
      ST_IDLE: begin hreadyout_s = 1'b1; hresp_s = HRESP_OKAY;  end
      ST_WAIT: begin hreadyout_s = 1'b0; hresp_s = HRESP_OKAY;  end
      ST_ERR1: begin hreadyout_s = 1'b0; hresp_s = HRESP_ERROR; end
      ST_ERR2: begin hreadyout_s = 1'b1; hresp_s = HRESP_ERROR; end
      default: begin hreadyout_s = 1'b1; hresp_s = HRESP_OKAY;  end
    endcase

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          if (err_s) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // The pipeline only advances when the whole bus is ready; a stall from
    // another slave leaves the pending address phase untouched.
    if (HREADY && hreadyout_s) begin
      dp_valid_d = accept_s;
      if (accept_s) begin
        addr_d  = HADDR[IDX_W+1:0];
        size_d  = HSIZE;
        write_d = HWRITE;
        err_d   = err_s;
      end else begin
        addr_d  = addr_q;
      end
    end else begin
      dp_valid_d = dp_valid_q;
    end
  end

  assign complete_s = dp_valid_q & hreadyout_s;

  // Write commit and read data selection in the completion cycle.
  always_comb begin
    we_s     = 4'b0000;
    hrdata_d = hrdata_q;
    if (complete_s && write_q && !err_q && HRESETn) begin
      we_s = byte_strobe(addr_q[1:0], size_q);
    end else begin
      we_s = 4'b0000;
    end
    if (complete_s && !write_q) begin
      hrdata_d = err_q ? '0 : mem_rdata_s;
    end else begin
      hrdata_d = hrdata_q;
    end
  end

  // State and data-phase registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      dp_valid_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      err_q      <= err_d;
      hrdata_q   <= hrdata_d;
    end
  end

  ahb_sram_bank #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk_i  (HCLK),
    .we_i   (we_s),
    .addr_i (addr_q[IDX_W+1:2]),
    .wdata_i(HWDATA),
    .rdata_o(mem_rdata_s)
  );

  // Read data is combinational in the completion cycle so a write committed
  // on the previous edge is visible without forwarding.
  assign HRDATA    = hrdata_d;
  assign HREADYOUT = hreadyout_s;
  assign HRESP     = hresp_s;
  assign HSPLIT    = '0;

endmodule
